// File: rtl/tlb_walk_ctrl_pkg.sv
// Shared constants for the TLB walk controller: page geometry, PTE field positions
// and the 3-bit FSM state encoding.
package tlb_pkg;

    localparam int ADDR_W      = 32;
    localparam int PAGE_SHIFT  = 12;
    localparam int PPN_W       = 8;
    localparam int PTE_V_BIT   = 0;
    localparam int PTE_PPN_LSB = PAGE_SHIFT;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOOKUP    = 3'd1;
    localparam logic [2:0] ST_WALK_REQ  = 3'd2;
    localparam logic [2:0] ST_WALK_WAIT = 3'd3;
    localparam logic [2:0] ST_FILL      = 3'd4;
    localparam logic [2:0] ST_RESP      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_LOOKUP    = ST_LOOKUP,
        S_WALK_REQ  = ST_WALK_REQ,
        S_WALK_WAIT = ST_WALK_WAIT,
        S_FILL      = ST_FILL,
        S_RESP      = ST_RESP
    } state_e;

endpackage

// File: rtl/tlb_walk_ctrl_if.sv
// TLB lookup/refill port and PTE memory port seen by the walk controller.
// master = controller side, slave = TLB / memory side.
interface tlb_walk_ctrl_if;
    import tlb_pkg::*;

    logic              tlb_lookup_valid;
    logic [ADDR_W-1:0] tlb_lookup_va;
    logic              tlb_lookup_hit;
    logic [ADDR_W-1:0] tlb_lookup_pa;
    logic              tlb_write_en;
    logic [ADDR_W-1:0] tlb_write_va;
    logic [ADDR_W-1:0] tlb_write_pa;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [ADDR_W-1:0] mem_resp_data;

    modport master (
        output tlb_lookup_valid, tlb_lookup_va, tlb_write_en, tlb_write_va, tlb_write_pa,
        output mem_req_valid, mem_req_addr,
        input  tlb_lookup_hit, tlb_lookup_pa, mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  tlb_lookup_valid, tlb_lookup_va, tlb_write_en, tlb_write_va, tlb_write_pa,
        input  mem_req_valid, mem_req_addr,
        output tlb_lookup_hit, tlb_lookup_pa, mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/tlb_walk_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the favoured client and flips
// to the other one after every accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    logic ptr_q, ptr_d;

    // NOTE: every combinational output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = req[ptr_q] ? ptr_q : ~ptr_q;
        ptr_d     = ptr_q;
        if (advance && gnt_valid) begin
            ptr_d = ~gnt_idx;
        end
    end

    // NOTE: flops use <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tlb_walk_ctrl.sv
// Translation sequencer: arbitrates two clients, looks up the TLB, walks a
// single-level page table on a miss, refills the TLB and returns PA or fault.
module tlb_walk_ctrl #(
    parameter int PPN_W     = tlb_pkg::PPN_W,
    parameter int PTE_V_BIT = tlb_pkg::PTE_V_BIT,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ptbr,
    input  logic             req0_valid,
    input  logic [31:0]      req0_va,
    output logic             resp0_valid,
    output logic [31:0]      resp0_pa,
    output logic             resp0_fault,
    input  logic             req1_valid,
    input  logic [31:0]      req1_va,
    output logic             resp1_valid,
    output logic [31:0]      resp1_pa,
    output logic             resp1_fault,
    tlb_walk_ctrl_if.master  bus,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] fault_cnt
);

    import tlb_pkg::*;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [31:0]       va_q, va_d;
    logic [31:0]       ptbr_q, ptbr_d;
    logic [31:0]       pa_q, pa_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;
    logic              arb_advance, arb_gnt_idx, arb_gnt_valid;
    logic [31:0]       pte_page;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({req1_valid, req0_valid}),
        .advance   (arb_advance),
        .gnt_idx   (arb_gnt_idx),
        .gnt_valid (arb_gnt_valid)
    );

    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        va_d             = va_q;
        ptbr_d           = ptbr_q;
        pa_d             = pa_q;
        fault_d          = fault_q;
        hit_cnt_d        = hit_cnt_q;
        miss_cnt_d       = miss_cnt_q;
        fault_cnt_d      = fault_cnt_q;
        arb_advance      = 1'b0;
        bus.tlb_lookup_valid = 1'b0;
        bus.tlb_write_en     = 1'b0;
        bus.mem_req_valid    = 1'b0;
        resp0_valid      = 1'b0;
        resp1_valid      = 1'b0;
        pte_page         = '0;
        pte_page[PAGE_SHIFT +: PPN_W] = bus.mem_resp_data[PTE_PPN_LSB +: PPN_W];

        unique case (state_q)
            S_IDLE: begin
                if (arb_gnt_valid) begin
                    arb_advance = 1'b1;
                    gnt_d       = arb_gnt_idx;
                    va_d        = arb_gnt_idx ? req1_va : req0_va;
                    pa_d        = '0;
                    fault_d     = 1'b0;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                bus.tlb_lookup_valid = 1'b1;
                if (bus.tlb_lookup_hit) begin
                    pa_d    = bus.tlb_lookup_pa;
                    state_d = S_RESP;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else begin
                    // ptbr is captured here so the walk uses the value seen on entry to WALK_REQ
                    ptbr_d  = ptbr;
                    state_d = S_WALK_REQ;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end
            end
            S_WALK_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = S_WALK_WAIT;
            end
            S_WALK_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (bus.mem_resp_data[PTE_V_BIT]) begin
                        pa_d    = pte_page;
                        state_d = S_FILL;
                    end else begin
                        pa_d    = '0;
                        fault_d = 1'b1;
                        state_d = S_RESP;
                        if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FILL: begin
                // pa_q holds the page address during FILL; the offset is merged for the response
                bus.tlb_write_en = 1'b1;
                pa_d    = {pa_q[31:PAGE_SHIFT], va_q[PAGE_SHIFT-1:0]};
                state_d = S_RESP;
            end
            S_RESP: begin
                resp0_valid = ~gnt_q;
                resp1_valid = gnt_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            va_q        <= '0;
            ptbr_q      <= '0;
            pa_q        <= '0;
            fault_q     <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            va_q        <= va_d;
            ptbr_q      <= ptbr_d;
            pa_q        <= pa_d;
            fault_q     <= fault_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign bus.tlb_lookup_va = va_q;
    assign bus.tlb_write_va  = va_q;
    assign bus.tlb_write_pa  = pa_q;
    assign bus.mem_req_addr  = ptbr_q + 32'({va_q[31:PAGE_SHIFT], 2'b00});
    assign resp0_pa          = pa_q;
    assign resp0_fault       = fault_q;
    assign resp1_pa          = pa_q;
    assign resp1_fault       = fault_q;
    assign busy              = (state_q != S_IDLE);
    assign hit_cnt           = hit_cnt_q;
    assign miss_cnt          = miss_cnt_q;
    assign fault_cnt         = fault_cnt_q;

endmodule

// File: tb/tb_tlb_walk_ctrl.sv
// Scoreboard bench for tlb_walk_ctrl: a TLB model, a page-table memory model and
// a second instance with 2-bit counters for saturation.
module tb_tlb_walk_ctrl;

    typedef struct packed {
        logic [31:0] pa;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ptbr;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_va, req1_va;
    logic        resp0_valid, resp1_valid, resp0_fault, resp1_fault;
    logic [31:0] resp0_pa, resp1_pa;
    logic        busy;
    logic [15:0] hit_cnt, miss_cnt, fault_cnt;

    logic        s_resp0_valid, s_resp1_valid, s_resp0_fault, s_resp1_fault, s_busy;
    logic [31:0] s_resp0_pa, s_resp1_pa;
    logic [1:0]  s_hit_cnt, s_miss_cnt, s_fault_cnt;

    tlb_walk_ctrl_if bus ();
    tlb_walk_ctrl_if bus_s ();

    tlb_walk_ctrl #(.PPN_W(8), .PTE_V_BIT(0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ptbr(ptbr),
        .req0_valid(req0_valid), .req0_va(req0_va),
        .resp0_valid(resp0_valid), .resp0_pa(resp0_pa), .resp0_fault(resp0_fault),
        .req1_valid(req1_valid), .req1_va(req1_va),
        .resp1_valid(resp1_valid), .resp1_pa(resp1_pa), .resp1_fault(resp1_fault),
        .bus(bus), .busy(busy),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .fault_cnt(fault_cnt)
    );

    tlb_walk_ctrl #(.PPN_W(8), .PTE_V_BIT(0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .ptbr(ptbr),
        .req0_valid(req0_valid), .req0_va(req0_va),
        .resp0_valid(s_resp0_valid), .resp0_pa(s_resp0_pa), .resp0_fault(s_resp0_fault),
        .req1_valid(req1_valid), .req1_va(req1_va),
        .resp1_valid(s_resp1_valid), .resp1_pa(s_resp1_pa), .resp1_fault(s_resp1_fault),
        .bus(bus_s), .busy(s_busy),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .fault_cnt(s_fault_cnt)
    );

    always #5 clk = ~clk;

    // TLB model: 4 entries indexed by va[13:12], tagged with the full VPN
    bit          tlb_v    [4];
    bit   [19:0] tlb_vpn  [4];
    bit   [31:0] tlb_page [4];
    logic        pre_en = 1'b0;
    logic [31:0] pre_va, pre_pa;
    int          wr_cnt;
    logic [31:0] wr_va, wr_pa;

    always_comb begin
        bus.tlb_lookup_hit = tlb_v[bus.tlb_lookup_va[13:12]] &&
                             (tlb_vpn[bus.tlb_lookup_va[13:12]] == bus.tlb_lookup_va[31:12]);
        bus.tlb_lookup_pa  = {tlb_page[bus.tlb_lookup_va[13:12]][31:12], bus.tlb_lookup_va[11:0]};
    end

    always_comb begin
        bus_s.tlb_lookup_hit = tlb_v[bus_s.tlb_lookup_va[13:12]] &&
                               (tlb_vpn[bus_s.tlb_lookup_va[13:12]] == bus_s.tlb_lookup_va[31:12]);
        bus_s.tlb_lookup_pa  = {tlb_page[bus_s.tlb_lookup_va[13:12]][31:12], bus_s.tlb_lookup_va[11:0]};
    end

    always @(posedge clk) begin
        if (bus.tlb_write_en) begin
            tlb_v[bus.tlb_write_va[13:12]]    <= 1'b1;
            tlb_vpn[bus.tlb_write_va[13:12]]  <= bus.tlb_write_va[31:12];
            tlb_page[bus.tlb_write_va[13:12]] <= bus.tlb_write_pa;
            wr_cnt <= wr_cnt + 1;
            wr_va  <= bus.tlb_write_va;
            wr_pa  <= bus.tlb_write_pa;
        end else if (pre_en) begin
            tlb_v[pre_va[13:12]]    <= 1'b1;
            tlb_vpn[pre_va[13:12]]  <= pre_va[31:12];
            tlb_page[pre_va[13:12]] <= pre_pa;
        end
    end

    // Page-table memory model with programmable ready and response delays
    bit   [31:0] pte_tab [bit [31:0]];
    int          rdy_dly = 0, resp_dly = 1;
    int          wait_cnt, pend_cnt, acc_cnt, resp_cnt;
    bit          pend, mem_ready, mem_rvalid;
    logic [31:0] pend_data, mem_rdata, acc_addr;

    assign bus.mem_req_ready    = mem_ready;
    assign bus.mem_resp_valid   = mem_rvalid;
    assign bus.mem_resp_data    = mem_rdata;
    assign bus_s.mem_req_ready  = mem_ready;
    assign bus_s.mem_resp_valid = mem_rvalid;
    assign bus_s.mem_resp_data  = mem_rdata;

    always @(posedge clk) begin
        mem_ready  <= 1'b0;
        mem_rvalid <= 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= pend_data;
                pend       <= 1'b0;
                resp_cnt   <= resp_cnt + 1;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
        if (bus.mem_req_valid && mem_ready) begin
            acc_cnt   <= acc_cnt + 1;
            acc_addr  <= bus.mem_req_addr;
            pend      <= 1'b1;
            pend_cnt  <= resp_dly;
            pend_data <= pte_tab.exists(bus.mem_req_addr) ? pte_tab[bus.mem_req_addr] : 32'h0;
            wait_cnt  <= 0;
        end else if (bus.mem_req_valid) begin
            if (wait_cnt >= rdy_dly) mem_ready <= 1'b1;
            else                     wait_cnt  <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // Scoreboard state
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    logic [31:0] pend_q0 [$];
    logic [31:0] pend_q1 [$];
    bit          order_q [$];
    int          exp_hit, exp_miss, exp_fault;
    bit          ptr_m;
    int          checks, failures;

    task automatic enqueue(input bit c, input logic [31:0] va, input logic [31:0] pa,
                           input bit fault, input bit hit);
        exp_t e;
        e.pa    = pa;
        e.fault = fault;
        if (c) begin pend_q1.push_back(va); exp_q1.push_back(e); end
        else   begin pend_q0.push_back(va); exp_q0.push_back(e); end
        if (hit) exp_hit++;
        else begin
            exp_miss++;
            if (fault) exp_fault++;
        end
    endtask

    task automatic kick();
        if (!req0_valid && pend_q0.size() > 0) begin req0_valid = 1'b1; req0_va = pend_q0.pop_front(); end
        if (!req1_valid && pend_q1.size() > 0) begin req1_valid = 1'b1; req1_va = pend_q1.pop_front(); end
    endtask

    // Pops one expectation per response; the client drops or re-raises its request on the response edge
    task automatic drain(input int n, input string tag, output int first_lat);
        int          got = 0;
        int          cyc = 0;
        exp_t        e;
        bit          c, b, f;
        logic [31:0] pa;
        first_lat = -1;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (resp0_valid || resp1_valid) begin
                checks++;
                if (resp0_valid && resp1_valid) begin
                    failures++;
                    $display("FAIL %s both_resp: resp0_valid=1 resp1_valid=1, required one-hot", tag);
                end
                c  = resp1_valid;
                pa = c ? resp1_pa : resp0_pa;
                f  = c ? resp1_fault : resp0_fault;
                if (first_lat < 0) first_lat = cyc;
                got++;
                checks++;
                if ((c ? exp_q1.size() : exp_q0.size()) == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_resp: client %0d responded with nothing outstanding", tag, c);
                end else begin
                    e = c ? exp_q1.pop_front() : exp_q0.pop_front();
                    if (pa !== e.pa) begin
                        failures++;
                        $display("FAIL %s resp%0d_pa: got %h required %h", tag, c, pa, e.pa);
                    end
                    checks++;
                    if (f !== e.fault) begin
                        failures++;
                        $display("FAIL %s resp%0d_fault: got %b required %b", tag, c, f, e.fault);
                    end
                end
                if (order_q.size() > 0) begin
                    b = order_q.pop_front();
                    checks++;
                    if (c !== b) begin
                        failures++;
                        $display("FAIL %s grant_order: got client %0d required client %0d", tag, c, b);
                    end
                end
                ptr_m = ~c;
                @(posedge clk);
                #1;
                if (c) req1_valid = 1'b0;
                else   req0_valid = 1'b0;
                kick();
            end
        end
        checks++;
        if (got < n) begin
            failures++;
            $display("FAIL %s timeout: got %0d responses required %0d", tag, got, n);
        end
    endtask

    task automatic check_counters(input string tag);
        checks++;
        if (hit_cnt !== 16'(exp_hit)) begin
            failures++;
            $display("FAIL %s hit_cnt: got %0d required %0d", tag, hit_cnt, exp_hit);
        end
        checks++;
        if (miss_cnt !== 16'(exp_miss)) begin
            failures++;
            $display("FAIL %s miss_cnt: got %0d required %0d", tag, miss_cnt, exp_miss);
        end
        checks++;
        if (fault_cnt !== 16'(exp_fault)) begin
            failures++;
            $display("FAIL %s fault_cnt: got %0d required %0d", tag, fault_cnt, exp_fault);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        ptbr       = 32'h0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_va    = 32'h0;
        req1_va    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, resp0_valid, resp1_valid, bus.tlb_lookup_valid, bus.tlb_write_en, bus.mem_req_valid} !== 6'b0) begin
            failures++;
            $display("FAIL reset strobes: got busy=%b r0=%b r1=%b lk=%b wr=%b mem=%b required all 0",
                     busy, resp0_valid, resp1_valid, bus.tlb_lookup_valid, bus.tlb_write_en, bus.mem_req_valid);
        end
        checks++;
        if (bus.mem_req_addr !== 32'h0 || resp0_pa !== 32'h0 || bus.tlb_lookup_va !== 32'h0) begin
            failures++;
            $display("FAIL reset data: got addr=%h pa=%h lva=%h required 0", bus.mem_req_addr, resp0_pa, bus.tlb_lookup_va);
        end
        check_counters("reset");
        reset = 1'b0;
    endtask

    task automatic test_hit();
        int lat;
        pre_va = 32'h0000_3000;
        pre_pa = 32'h0000_5000;
        pre_en = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        enqueue(1'b0, 32'h0000_3ABC, 32'h0000_5ABC, 1'b0, 1'b1);
        kick();
        drain(1, "hit", lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL hit latency: got response in cycle %0d required 3 (grant + 2)", lat);
        end
        check_counters("hit");
    endtask

    task automatic test_miss_refill();
        int lat;
        int acc0;
        ptbr = 32'h0000_1000;
        pte_tab[32'h0000_101C] = 32'h0004_2001;
        enqueue(1'b1, 32'h0000_7010, 32'h0004_2010, 1'b0, 1'b0);
        kick();
        drain(1, "miss", lat);
        checks++;
        if (acc_addr !== 32'h0000_101C) begin
            failures++;
            $display("FAIL miss mem_req_addr: got %h required %h", acc_addr, 32'h0000_101C);
        end
        checks++;
        if (wr_cnt !== 1 || wr_va !== 32'h0000_7010 || wr_pa !== 32'h0004_2000) begin
            failures++;
            $display("FAIL miss tlb_write: got cnt=%0d va=%h pa=%h required 1/00007010/00042000", wr_cnt, wr_va, wr_pa);
        end
        check_counters("miss");
        acc0 = acc_cnt;
        enqueue(1'b1, 32'h0000_7010, 32'h0004_2010, 1'b0, 1'b1);
        kick();
        drain(1, "rehit", lat);
        checks++;
        if (lat !== 3 || acc_cnt !== acc0 || wr_cnt !== 1) begin
            failures++;
            $display("FAIL rehit path: got lat=%0d walks=%0d writes=%0d required 3/%0d/1", lat, acc_cnt, wr_cnt, acc0);
        end
        check_counters("rehit");
    endtask

    task automatic test_fault();
        int lat;
        int wr0;
        wr0 = wr_cnt;
        pte_tab[32'h0000_1028] = 32'h0004_2000;
        enqueue(1'b1, 32'h0000_A123, 32'h0000_0000, 1'b1, 1'b0);
        kick();
        drain(1, "fault", lat);
        checks++;
        if (wr_cnt !== wr0) begin
            failures++;
            $display("FAIL fault tlb_write: got %0d writes required %0d", wr_cnt, wr0);
        end
        check_counters("fault");
    endtask

    task automatic test_contention();
        int lat;
        bit p;
        p = ptr_m;
        for (int i = 0; i < 4; i++) begin
            order_q.push_back(p);
            p = ~p;
        end
        enqueue(1'b0, 32'h0000_7001, 32'h0004_2001, 1'b0, 1'b1);
        enqueue(1'b1, 32'h0000_7002, 32'h0004_2002, 1'b0, 1'b1);
        enqueue(1'b0, 32'h0000_7003, 32'h0004_2003, 1'b0, 1'b1);
        enqueue(1'b1, 32'h0000_7004, 32'h0004_2004, 1'b0, 1'b1);
        kick();
        drain(4, "contention", lat);
        check_counters("contention");
    endtask

    task automatic test_reset_mid_walk();
        int  base, cyc, wr0, rc0;
        bit  saw_resp, saw_busy;
        pte_tab[32'h0000_104C] = 32'h0005_5001;
        rdy_dly  = 3;
        resp_dly = 4;
        base     = acc_cnt;
        req0_valid = 1'b1;
        req0_va    = 32'h0001_3000;
        cyc = 0;
        while (acc_cnt == base && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (acc_cnt == base) begin
            failures++;
            $display("FAIL rst_walk accept_timeout: no PTE request accepted in %0d cycles", cyc);
        end
        checks++;
        if (busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_walk wait_state: got busy=%b mem_req_valid=%b required 1/0", busy, bus.mem_req_valid);
        end
        wr0   = wr_cnt;
        rc0   = resp_cnt;
        reset = 1'b1;
        req0_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.tlb_write_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_walk in_reset: got busy=%b mem=%b wr=%b required 0/0/0", busy, bus.mem_req_valid, bus.tlb_write_en);
        end
        ptr_m     = 1'b0;
        exp_hit   = 0;
        exp_miss  = 0;
        exp_fault = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        saw_resp = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) saw_resp = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        checks++;
        if (resp_cnt !== rc0 + 1) begin
            failures++;
            $display("FAIL rst_walk stale_pte: got %0d late PTE responses required 1", resp_cnt - rc0);
        end
        checks++;
        if (saw_resp || saw_busy || wr_cnt !== wr0) begin
            failures++;
            $display("FAIL rst_walk stale_effect: got resp=%b busy=%b writes=%0d required 0/0/%0d", saw_resp, saw_busy, wr_cnt, wr0);
        end
        check_counters("rst_walk");
        rdy_dly  = 0;
        resp_dly = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        int lat;
        int exp_sat;
        for (int i = 0; i < 5; i++) begin
            enqueue(1'(i % 2), 32'h0000_7100 + 32'(i), 32'h0004_2100 + 32'(i), 1'b0, 1'b1);
        end
        kick();
        drain(5, "saturation", lat);
        check_counters("saturation");
        exp_sat = (exp_hit > 3) ? 3 : exp_hit;
        checks++;
        if (s_hit_cnt !== 2'(exp_sat)) begin
            failures++;
            $display("FAIL saturation sat_hit_cnt: got %0d required %0d", s_hit_cnt, exp_sat);
        end
        checks++;
        if (s_miss_cnt !== 2'd0 || s_fault_cnt !== 2'd0) begin
            failures++;
            $display("FAIL saturation sat_miss_fault: got %0d/%0d required 0/0", s_miss_cnt, s_fault_cnt);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        ptr_m    = 1'b0;
        test_reset();
        test_hit();
        test_miss_refill();
        test_fault();
        test_contention();
        test_reset_mid_walk();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
